// File: rtl/relm_ps2_rx_pkg.sv
// Shared constants and types for the PS/2 receive block.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package relm_ps2_rx_pkg;

   localparam int RELM_WD      = 32;  // default CPU word width; retry/strobe bit sits at bit WD
   localparam int FRAME_LEN    = 11;  // start + 8 data + parity + stop
   localparam int SHIFT_LEN    = FRAME_LEN - 1;  // bits captured after the start bit
   localparam int FILT_LEN     = 8;   // samples that must agree before the filtered level flips

   // pop_q field positions (retry lives at bit WD, which follows the WD parameter)
   localparam int POP_RETRY_BIT = RELM_WD;
   localparam int POP_ERR_BIT   = 9;
   localparam int POP_OVF_BIT   = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } rx_state_e;

   // Captured frame is {stop, parity, data[7:0]}; good frames have stop=1 and odd parity.
   function automatic logic frame_ok(input logic [SHIFT_LEN-1:0] f);
      return f[SHIFT_LEN-1] && (^f[SHIFT_LEN-2:0]);
   endfunction

endpackage

// File: rtl/relm_ps2_filter.sv
// Pin conditioner: 2-flop synchronizer, 8-sample agreement filter, falling-edge pulse.
// Latency: 2 sync + 8 filter + 1 level flop; fall_out is high the cycle after the level drops.
// Backpressure: none; free-running.
// Ports: clk / rst_n_in (sync, active-low), pin_in (async raw pin),
//        lvl_out (filtered level), fall_out (one-cycle pulse after filtered 1->0).
module relm_ps2_filter
   import relm_ps2_rx_pkg::*;
(
   input  logic clk,
   input  logic rst_n_in,
   input  logic pin_in,
   output logic lvl_out,
   output logic fall_out
);

   logic                sync1_q, sync1_d;
   logic                sync2_q, sync2_d;
   logic [FILT_LEN-1:0] filt_q,  filt_d;
   logic                lvl_q,   lvl_d;
   logic                lvl_dly_q, lvl_dly_d;

   always_comb begin
      sync1_d   = pin_in;
      sync2_d   = sync1_q;
      filt_d    = {filt_q[FILT_LEN-2:0], sync2_q};
      lvl_dly_d = lvl_q;
      lvl_d     = lvl_q;
      // Hysteresis: only a full window of the opposite value moves the level.
      if (filt_q == '0) begin
         lvl_d = 1'b0;
      end else if (&filt_q) begin
         lvl_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n_in) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         filt_q    <= '1;
         lvl_q     <= 1'b1;
         lvl_dly_q <= 1'b1;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         filt_q    <= filt_d;
         lvl_q     <= lvl_d;
         lvl_dly_q <= lvl_dly_d;
      end
   end

   assign lvl_out  = lvl_q;
   assign fall_out = lvl_dly_q & ~lvl_q;

endmodule

// File: rtl/relm_ps2_rx.sv
// PS/2 device-to-host receiver with a byte FIFO read through a CPU pop port.
// Latency: byte pushed the cycle after the stop-bit fall pulse, visible on pop_q one cycle later.
// Backpressure: none toward the PS/2 bus; a full FIFO drops new bytes and raises the overflow sticky.
// Ports: clk / rst_n_in (sync, active-low), ps2_clk_in / ps2_dat_in (async raw pins),
//        pop_d[WD] pop strobe (other bits ignored),
//        pop_q {retry@WD, err@9, ovf@8, head byte@7:0}, combinational.
module relm_ps2_rx
   import relm_ps2_rx_pkg::*;
#(
   parameter int WD      = RELM_WD,
   parameter int WFIFO   = 4,
   parameter int TIMEOUT = 100000
) (
   input  logic        clk,
   input  logic        rst_n_in,
   input  logic        ps2_clk_in,
   input  logic        ps2_dat_in,
   input  logic [WD:0] pop_d,
   output logic [WD:0] pop_q
);

   localparam int DEPTH = 2 ** WFIFO;
   localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [3:0]    CNT_LAST = 4'(SHIFT_LEN - 1);

   // ---------------- pin conditioning ----------------
   logic unused_clk_lvl;
   logic clk_fall;
   logic dat_lvl;
   logic unused_dat_fall;
   logic unused_pop_bits;

   assign unused_pop_bits = ^pop_d[WD-1:0];

   relm_ps2_filter u_clk_filt (
      .clk      (clk),
      .rst_n_in (rst_n_in),
      .pin_in   (ps2_clk_in),
      .lvl_out  (unused_clk_lvl),
      .fall_out (clk_fall)
   );

   relm_ps2_filter u_dat_filt (
      .clk      (clk),
      .rst_n_in (rst_n_in),
      .pin_in   (ps2_dat_in),
      .lvl_out  (dat_lvl),
      .fall_out (unused_dat_fall)
   );

   // ---------------- frame FSM ----------------
   rx_state_e            state_q, state_d;
   logic [3:0]           cnt_q,   cnt_d;
   logic [TW-1:0]        tmo_q,   tmo_d;
   logic [SHIFT_LEN-1:0] shreg_q, shreg_d;
   logic                 push_q,  push_d;
   logic [7:0]           push_byte_q, push_byte_d;
   logic                 err_set;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      shreg_d     = shreg_q;
      push_d      = 1'b0;
      push_byte_d = push_byte_q;
      err_set     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clk_fall) begin
               if (!dat_lvl) begin
                  state_d = ST_SHIFT;
                  cnt_d   = '0;
                  tmo_d   = '0;
               end else begin
                  // A clock fall with data high cannot be a start bit.
                  err_set = 1'b1;
               end
            end
         end
         ST_SHIFT: begin
            if (clk_fall) begin
               shreg_d = {dat_lvl, shreg_q[SHIFT_LEN-1:1]};
               cnt_d   = cnt_q + 4'd1;
               tmo_d   = '0;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  if (frame_ok(shreg_d)) begin
                     push_d      = 1'b1;
                     push_byte_d = shreg_d[7:0];
                  end else begin
                     err_set = 1'b1;
                  end
               end
            end else if (tmo_q == TMO_LAST) begin
               // Device stalled mid-frame: abandon it.
               state_d = ST_IDLE;
               cnt_d   = '0;
               tmo_d   = '0;
               err_set = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FIFO and stickies ----------------
   logic [7:0]       mem_q [DEPTH];
   logic [7:0]       mem_d [DEPTH];
   logic [WFIFO-1:0] wr_ptr_q, wr_ptr_d;
   logic [WFIFO-1:0] rd_ptr_q, rd_ptr_d;
   logic [WFIFO:0]   count_q,  count_d;
   logic             err_q,    err_d;
   logic             ovf_q,    ovf_d;
   logic             pop_vld, fifo_full, push_ok, ovf_set;

   always_comb begin
      pop_vld   = pop_d[WD] && (count_q != '0);
      fifo_full = (count_q == (WFIFO+1)'(DEPTH));
      // A same-cycle pop frees the slot, so a full FIFO can still accept.
      push_ok   = push_q && (!fifo_full || pop_vld);
      ovf_set   = push_q && fifo_full && !pop_vld;

      mem_d = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_byte_q;
      end
      wr_ptr_d = wr_ptr_q + WFIFO'(push_ok);
      rd_ptr_d = rd_ptr_q + WFIFO'(pop_vld);

      count_d = count_q;
      case ({push_ok, pop_vld})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Set wins over the pop-clear in the same cycle.
      err_d = err_set | (err_q & ~pop_vld);
      ovf_d = ovf_set | (ovf_q & ~pop_vld);
   end

   always_comb begin
      pop_q                = '0;
      pop_q[WD]            = (count_q == '0);
      pop_q[POP_ERR_BIT]   = err_q;
      pop_q[POP_OVF_BIT]   = ovf_q;
      // Storage is not reset, so hide stale contents while empty.
      pop_q[7:0]           = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n_in) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         tmo_q       <= '0;
         shreg_q     <= '0;
         push_q      <= 1'b0;
         push_byte_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         shreg_q     <= shreg_d;
         push_q      <= push_d;
         push_byte_q <= push_byte_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         err_q       <= err_d;
         ovf_q       <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_relm_ps2_rx.sv
// Randomized bench for relm_ps2_rx against a queue-based frame/FIFO model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_relm_ps2_rx;

   localparam int WD      = 32;
   localparam int WFIFO   = 4;
   localparam int DEPTH   = 2 ** WFIFO;
   localparam int TIMEOUT = 400;
   localparam int HP      = 25;   // PS/2 half-period in core cycles

   logic        clk = 1'b0;
   logic        rst_n_in;
   logic        ps2_clk_in;
   logic        ps2_dat_in;
   logic [WD:0] pop_d;
   logic [WD:0] pop_q;

   always #5 clk = ~clk;

   relm_ps2_rx #(
      .WD      (WD),
      .WFIFO   (WFIFO),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n_in   (rst_n_in),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .pop_d      (pop_d),
      .pop_q      (pop_q)
   );

   // ---------------- reference model ----------------
   logic [7:0] mdl_q[$];
   bit         mdl_err;
   bit         mdl_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [WD:0] mdl_popq();
      logic [WD:0] e;
      e     = '0;
      e[WD] = (mdl_q.size() == 0);
      e[9]  = mdl_err;
      e[8]  = mdl_ovf;
      if (mdl_q.size() != 0) e[7:0] = mdl_q[0];
      return e;
   endfunction

   task automatic chk(input string tag, input logic [WD:0] got, input logic [WD:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic mdl_pop();
      if (mdl_q.size() != 0) begin
         void'(mdl_q.pop_front());
         mdl_err = 0;
         mdl_ovf = 0;
      end
   endtask

   task automatic mdl_frame(input logic [7:0] b, input bit good);
      if (!good)                      mdl_err = 1;
      else if (mdl_q.size() < DEPTH)  mdl_q.push_back(b);
      else                            mdl_ovf = 1;
   endtask

   // ---------------- stimulus ----------------
   task automatic cpu_pop(input string tag);
      @(negedge clk);
      chk(tag, pop_q, mdl_popq());
      pop_d = {1'b1, 32'($urandom)};
      @(posedge clk);
      #1 pop_d = {1'b0, 32'($urandom)};
      mdl_pop();
   endtask

   // One PS/2 bit: data set while clock high, then clock low for low_cyc cycles.
   // With pop_at_push, pops on exactly the cycle the receiver pushes its byte.
   task automatic ps2_bit(input logic d, input int low_cyc, input bit pop_at_push, output bit popped);
      popped = 0;
      @(negedge clk);
      ps2_dat_in = d;
      repeat (HP - 1) @(negedge clk);
      ps2_clk_in = 1'b0;
      for (int i = 0; i < low_cyc; i++) begin
         @(negedge clk);
         if (pop_at_push && !popped && dut.push_q) begin
            pop_d  = {1'b1, 32'($urandom)};
            popped = 1;
            @(posedge clk);
            #1 pop_d = {1'b0, 32'($urandom)};
         end
      end
      @(negedge clk);
      ps2_clk_in = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_push, output bit popped);
      logic [10:0] bits;
      bit          p;
      bits   = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      popped = 0;
      for (int i = 0; i < 11; i++) begin
         ps2_bit(bits[i], HP, pop_at_push && (i == 10), p);
         popped = popped | p;
      end
      repeat (HP) @(negedge clk);
      if (popped) mdl_pop();
      mdl_frame(b, !bad_par);
   endtask

   task automatic frame(input logic [7:0] b, input bit bad_par);
      bit p;
      send_frame(b, bad_par, 1'b0, p);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n_in = 1'b0;
      repeat (4) @(negedge clk);
      rst_n_in = 1'b1;
      mdl_q.delete();
      mdl_err = 0;
      mdl_ovf = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      bit          p;
      logic [7:0]  b;
      logic [WD:0] one_bit;

      ps2_clk_in = 1'b1;
      ps2_dat_in = 1'b1;
      pop_d      = '0;
      rst_n_in   = 1'b0;
      one_bit    = 1;
      repeat (5) @(negedge clk);
      rst_n_in = 1'b1;
      mdl_q.delete();
      mdl_err = 0;
      mdl_ovf = 0;

      // Reset state: retry=1, everything else 0.
      @(negedge clk);
      chk("reset_popq", pop_q, one_bit << WD);

      // Good frame 0x1C, then pop.
      frame(8'h1C, 1'b0);
      @(negedge clk);
      chk("good_1c", pop_q, 33'h0_0000_001C);
      cpu_pop("pop_1c");
      @(negedge clk);
      chk("empty_after_1c", pop_q, mdl_popq());

      // Bad parity: no push, error sticky.
      frame(8'h1C, 1'b1);
      @(negedge clk);
      chk("badpar", pop_q, (one_bit << WD) | (one_bit << 9));

      // Clear the error with a real pop before the timeout case.
      frame(8'h33, 1'b0);
      cpu_pop("pop_33");

      // Timeout: start + 4 bits, then clock held low past TIMEOUT.
      ps2_bit(1'b0, HP, 1'b0, p);
      ps2_bit(1'b1, HP, 1'b0, p);
      ps2_bit(1'b0, HP, 1'b0, p);
      ps2_bit(1'b1, HP, 1'b0, p);
      ps2_bit(1'b1, HP, 1'b0, p);
      ps2_bit(1'b0, TIMEOUT + 50, 1'b0, p);
      repeat (HP) @(negedge clk);
      mdl_err = 1;
      chk("timeout_err", pop_q, mdl_popq());
      frame(8'hF0, 1'b0);
      @(negedge clk);
      chk("after_timeout_f0", pop_q, mdl_popq());
      cpu_pop("pop_f0");

      // Overflow: 17 frames, 16 kept in order.
      for (int i = 0; i < 17; i++) frame(8'(i), 1'b0);
      for (int i = 0; i < DEPTH; i++) cpu_pop($sformatf("ovf_pop%0d", i));
      @(negedge clk);
      chk("ovf_drained", pop_q, mdl_popq());

      // Full FIFO with a pop on the push cycle: byte accepted, no overflow.
      for (int i = 0; i < DEPTH; i++) frame(8'($urandom), 1'b0);
      send_frame(8'hA5, 1'b0, 1'b1, p);
      chk("pop_at_push_hit", {32'd0, p}, 33'd1);
      @(negedge clk);
      chk("pop_at_push_state", pop_q, mdl_popq());
      for (int i = 0; i < DEPTH; i++) cpu_pop($sformatf("full_pop%0d", i));
      @(negedge clk);
      chk("full_drained", pop_q, mdl_popq());

      // Short clock glitch on an idle bus must not register as a fall.
      @(negedge clk);
      ps2_clk_in = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk_in = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch_ignored", pop_q, mdl_popq());

      // Reset mid-frame, then a clean frame.
      ps2_bit(1'b0, HP, 1'b0, p);
      ps2_bit(1'b1, HP, 1'b0, p);
      ps2_bit(1'b1, HP, 1'b0, p);
      do_reset();
      @(negedge clk);
      chk("reset_midframe", pop_q, one_bit << WD);
      frame(8'h5A, 1'b0);
      cpu_pop("pop_5a");

      // Randomized frames and pops.
      for (int i = 0; i < 24; i++) begin
         b = 8'($urandom);
         frame(b, $urandom_range(0, 4) == 0);
         @(negedge clk);
         chk($sformatf("rnd_frame%0d", i), pop_q, mdl_popq());
         repeat ($urandom_range(0, 2)) cpu_pop($sformatf("rnd_pop%0d", i));
      end
      while (mdl_q.size() != 0) cpu_pop("rnd_drain");
      @(negedge clk);
      chk("final_empty", pop_q, mdl_popq());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/relm_ps2_rx.md
RELM_PS2_RX -- requirements
Module: relm_ps2_rx

Interface
REQ-001 SHALL have parameter WD, default 32; CPU word width, with bit WD as the strobe/retry bit.
REQ-002 SHALL have parameter WFIFO, default 4; receive FIFO depth is 2**WFIFO bytes.
REQ-003 SHALL have parameter TIMEOUT, default 100000; cycles allowed between PS/2 clock falling edges inside a frame.
REQ-004 SHALL have ports: clk  input  1  sole clock; rising edge.
REQ-005 SHALL have port: rst_n_in  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port: ps2_clk_in  input  1  raw PS/2 clock pin; asynchronous.
REQ-007 SHALL have port: ps2_dat_in  input  1  raw PS/2 data pin; asynchronous.
REQ-008 SHALL have port: pop_d  input  WD+1  CPU pop port; bit WD is the pop strobe; bits [WD-1:0] are ignored.
REQ-009 SHALL have port: pop_q  output  WD+1  CPU pop result: [WD]=retry (FIFO empty), [9]=error sticky, [8]=overflow sticky, [7:0]=head byte, all other bits 0.

Function
REQ-010 SHALL pass each pin through a 2-flop synchronizer, then an 8-sample shift filter; the filtered level changes only when all 8 samples equal the opposite value.
REQ-011 SHALL generate a one-cycle fall pulse on the cycle after filtered clock goes 1->0; all sampling uses filtered data at that pulse.
REQ-012 SHALL implement FSM states IDLE and SHIFT.
REQ-013 IDLE, on fall with data=0 (start bit): go to SHIFT, clear bit counter and timeout counter.
REQ-014 IDLE, on fall with data=1: stay in IDLE and set error sticky.
REQ-015 SHIFT, on each fall: shift data into a 10-bit register LSB-first (8 data, parity, stop) and increment the counter.
REQ-016 SHIFT, on the 10th fall: return to IDLE.
REQ-017 When that frame has stop=1 and odd parity (XOR of data and parity = 1), SHALL push the byte on the next cycle; otherwise it SHALL drop the byte and set error sticky.
REQ-018 SHIFT timeout: the counter clears on every fall; reaching TIMEOUT-1 SHALL force IDLE and set error sticky, with no push.
REQ-019 Push into a full FIFO with no same-cycle pop SHALL drop the byte, set overflow sticky, and leave the FIFO unchanged.
REQ-020 Push into a full FIFO with a same-cycle valid pop SHALL succeed; occupancy stays at full.
REQ-021 pop_q SHALL be combinational from FIFO head, count and stickies; retry=1 iff count==0.
REQ-022 A pop (pop_d[WD]=1 and count!=0) SHALL advance head at that clock edge and clear both stickies.
REQ-023 A pop when count==0 SHALL change nothing.
REQ-024 A set and a clear of the same sticky in one cycle SHALL leave it set.
REQ-025 A push and a valid pop in one cycle SHALL keep count unchanged; pointers SHALL wrap modulo 2**WFIFO.
REQ-026 Push-to-visible latency SHALL be 1 cycle: a pushed byte appears in pop_q the cycle after the push.

Reset
REQ-027 rst_n_in=0 at a clock edge SHALL set: state IDLE, counters 0, FIFO empty, stickies 0, synchronizers and filters all-ones (idle bus level).
REQ-028 Reset mid-frame SHALL discard the partial frame; after release, the next start bit is accepted normally.
REQ-029 pop_q SHALL read {1, zeros} the cycle after reset.

Structure
REQ-030 WD default, frame length (11), filter length (8) and the pop_q bit positions (retry, error, overflow) SHALL be constants in the shared relm package.
REQ-031 Synchronizer plus filter plus edge detect SHALL be one sub-module, relm_ps2_filter, instantiated twice (fall output used for clock only).
REQ-032 The FIFO SHALL be a register array inside relm_ps2_rx.

Verification
REQ-033 Frame 0x1C, parity 0, stop 1, half-period 2000 cycles -> pop_q=0x01C with retry 0; one pop -> retry 1.
REQ-034 Frame 0x1C, parity 1 -> no push; pop_q[9]=1, retry=1.
REQ-035 Clock held low after 4 bits for TIMEOUT cycles -> IDLE with error set; a following valid frame 0xF0 -> pop_q[7:0]=0xF0.
REQ-036 17 valid frames 0x00..0x10, no pops -> 16 bytes 0x00..0x0F read in order; overflow flag seen with the first pop, then cleared.
REQ-037 Valid frame pushed on the same cycle as a pop with FIFO full -> count stays 16, no overflow, byte kept.
REQ-038 2-cycle glitch on ps2_clk_in and rst_n_in=0 mid-frame -> no bit sampled; after reset, frame 0x5A received correctly.
